// File: rtl/fflop_pkg.sv
// rtl/fflop_pkg.sv - shared state encoding and widths for the fflop shelf
package fflop_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/a_latch.sv
// rtl/a_latch.sv - enabled data register with async active-low reset
module a_latch #(
  parameter int              SIZE    = 8,
  parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [SIZE-1:0] idat,
  output logic [SIZE-1:0] odat
);

  logic [SIZE-1:0] dat_d;
  logic [SIZE-1:0] dat_q;

  always_comb begin
    dat_d = dat_q;
    if (ena) dat_d = idat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dat_q <= RST_VAL;
    else        dat_q <= dat_d;
  end

  assign odat = dat_q;

endmodule

// File: rtl/a_skid_buf.sv
// rtl/a_skid_buf.sv - two-entry valid/ready skid buffer, registered i_rdy/o_vld
// Optional stall counter output stall_cnt when A_SKID_BUF_STAT_EN is defined.
module a_skid_buf
  import fflop_pkg::*;
#(
  parameter int              SIZE    = 8,
  parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vld,
  output logic              i_rdy,
  input  logic [SIZE-1:0]   idat,
  output logic              o_vld,
  input  logic              o_rdy,
  output logic [SIZE-1:0]   odat
`ifdef A_SKID_BUF_STAT_EN
  ,
  output logic [STAT_W-1:0] stall_cnt
`endif
);

  state_e          state_d;
  state_e          state_q;
  logic            load_main;
  logic            load_skid;
  logic            sel_skid;
  logic            in_xfer;
  logic            out_xfer;
  logic [SIZE-1:0] skid_dat;
  logic [SIZE-1:0] main_din;

  // Handshake outputs decode only the state register, so o_rdy never reaches i_rdy.
  assign i_rdy    = (state_q == EMPTY) || (state_q == BUSY);
  assign o_vld    = (state_q == BUSY)  || (state_q == FULL);
  assign in_xfer  = i_vld && i_rdy;
  assign out_xfer = o_vld && o_rdy;

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    sel_skid  = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d   = BUSY;
          load_main = 1'b1;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_d   = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d   = BUSY;
          load_main = 1'b1;
          sel_skid  = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  assign main_din = sel_skid ? skid_dat : idat;

  a_latch #(.SIZE(SIZE), .RST_VAL(RST_VAL)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (load_main),
    .idat  (main_din),
    .odat  (odat)
  );

  a_latch #(.SIZE(SIZE), .RST_VAL(RST_VAL)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (load_skid),
    .idat  (idat),
    .odat  (skid_dat)
  );

`ifdef A_SKID_BUF_STAT_EN
  logic [STAT_W-1:0] stall_cnt_d;
  logic [STAT_W-1:0] stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (o_vld && !o_rdy && (stall_cnt_q != {STAT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_a_skid_buf.sv
// tb/tb_a_skid_buf.sv - directed and scoreboarded bench for a_skid_buf
module tb_a_skid_buf;

  logic       clk;
  logic       rst_n;
  logic       i_vld;
  logic       i_rdy;
  logic [7:0] idat;
  logic       o_vld;
  logic       o_rdy;
  logic [7:0] odat;
`ifdef A_SKID_BUF_STAT_EN
  logic [15:0] stall_cnt;
`endif

  int checks;
  int errors;

  a_skid_buf #(.SIZE(8), .RST_VAL(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (i_vld),
    .i_rdy (i_rdy),
    .idat  (idat),
    .o_vld (o_vld),
    .o_rdy (o_rdy),
    .odat  (odat)
`ifdef A_SKID_BUF_STAT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_vld = 1'b0; o_rdy = 1'b0; idat = 8'h00;
    #3;
    checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL reset_o_vld got %b exp 0", o_vld); end
    checks++; if (i_rdy !== 1'b1) begin errors++; $display("FAIL reset_i_rdy got %b exp 1", i_rdy); end
    checks++; if (odat !== 8'h00) begin errors++; $display("FAIL reset_odat got %h exp 00", odat); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (o_vld !== 1'b0 || i_rdy !== 1'b1) begin
      errors++; $display("FAIL post_reset_state got o_vld=%b i_rdy=%b exp 0 1", o_vld, i_rdy);
    end
  endtask

  task automatic test_streaming();
    o_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      i_vld = (k < 16);
      idat  = 8'(k + 1);
      step();
      checks++; if (i_rdy !== 1'b1) begin errors++; $display("FAIL stream_i_rdy k=%0d got %b exp 1", k, i_rdy); end
      checks++; if (o_vld !== (k < 16)) begin errors++; $display("FAIL stream_o_vld k=%0d got %b exp %b", k, o_vld, (k < 16)); end
      if (k < 16) begin
        checks++; if (odat !== 8'(k + 1)) begin errors++; $display("FAIL stream_odat k=%0d got %h exp %h", k, odat, 8'(k + 1)); end
      end
    end
    i_vld = 1'b0;
  endtask

  task automatic test_backpressure();
    o_rdy = 1'b0;
    i_vld = 1'b1; idat = 8'hA1;
    step();
    checks++; if (o_vld !== 1'b1 || i_rdy !== 1'b1 || odat !== 8'hA1) begin
      errors++; $display("FAIL bp_busy got o_vld=%b i_rdy=%b odat=%h exp 1 1 a1", o_vld, i_rdy, odat);
    end
    idat = 8'hA2;
    step();
    checks++; if (o_vld !== 1'b1 || i_rdy !== 1'b0 || odat !== 8'hA1) begin
      errors++; $display("FAIL bp_full got o_vld=%b i_rdy=%b odat=%h exp 1 0 a1", o_vld, i_rdy, odat);
    end
    idat = 8'hA3;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (o_vld !== 1'b1 || i_rdy !== 1'b0 || odat !== 8'hA1) begin
        errors++; $display("FAIL bp_hold k=%0d got o_vld=%b i_rdy=%b odat=%h exp 1 0 a1", k, o_vld, i_rdy, odat);
      end
    end
    o_rdy = 1'b1;
    step();
    checks++; if (o_vld !== 1'b1 || i_rdy !== 1'b1 || odat !== 8'hA2) begin
      errors++; $display("FAIL bp_drain1 got o_vld=%b i_rdy=%b odat=%h exp 1 1 a2", o_vld, i_rdy, odat);
    end
    step();
    checks++; if (o_vld !== 1'b1 || odat !== 8'hA3) begin
      errors++; $display("FAIL bp_drain2 got o_vld=%b odat=%h exp 1 a3", o_vld, odat);
    end
    i_vld = 1'b0;
    step();
    checks++; if (o_vld !== 1'b0 || i_rdy !== 1'b1) begin
      errors++; $display("FAIL bp_empty got o_vld=%b i_rdy=%b exp 0 1", o_vld, i_rdy);
    end
  endtask

  task automatic test_simultaneous();
    o_rdy = 1'b0; i_vld = 1'b1; idat = 8'h55;
    step();
    checks++; if (odat !== 8'h55 || o_vld !== 1'b1) begin
      errors++; $display("FAIL sim_load got odat=%h o_vld=%b exp 55 1", odat, o_vld);
    end
    idat = 8'h66; o_rdy = 1'b1;
    step();
    checks++; if (odat !== 8'h66 || o_vld !== 1'b1 || i_rdy !== 1'b1) begin
      errors++; $display("FAIL sim_busy got odat=%h o_vld=%b i_rdy=%b exp 66 1 1", odat, o_vld, i_rdy);
    end
    i_vld = 1'b0;
    step();
    checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL sim_empty got o_vld=%b exp 0", o_vld); end
  endtask

  task automatic test_reset_mid();
    o_rdy = 1'b0; i_vld = 1'b1; idat = 8'hB1;
    step();
    idat = 8'hB2;
    step();
    checks++; if (i_rdy !== 1'b0 || odat !== 8'hB1) begin
      errors++; $display("FAIL rmid_full got i_rdy=%b odat=%h exp 0 b1", i_rdy, odat);
    end
    i_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (o_vld !== 1'b0 || i_rdy !== 1'b1 || odat !== 8'h00) begin
      errors++; $display("FAIL rmid_async got o_vld=%b i_rdy=%b odat=%h exp 0 1 00", o_vld, i_rdy, odat);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (o_vld !== 1'b0 || i_rdy !== 1'b1) begin
      errors++; $display("FAIL rmid_release got o_vld=%b i_rdy=%b exp 0 1", o_vld, i_rdy);
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic       held_v;
    logic [7:0] held_d;
    logic [7:0] exp_d;
    held_v = 1'b0;
    held_d = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      if (held_v) begin
        checks++; if (o_vld !== 1'b1 || odat !== held_d) begin
          errors++; $display("FAIL rnd_stable c=%0d got o_vld=%b odat=%h exp 1 %h", c, o_vld, odat, held_d);
        end
      end
      checks++; if (i_rdy !== (q.size() < 2) || o_vld !== (q.size() > 0)) begin
        errors++; $display("FAIL rnd_occupancy c=%0d got i_rdy=%b o_vld=%b exp count %0d", c, i_rdy, o_vld, q.size());
      end
      i_vld = 1'($urandom_range(1, 0));
      o_rdy = 1'($urandom_range(1, 0));
      idat  = 8'($urandom);
      if (o_vld && o_rdy) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_dup c=%0d got %h exp none", c, odat);
        end else begin
          exp_d = q.pop_front();
          if (odat !== exp_d) begin errors++; $display("FAIL rnd_order c=%0d got %h exp %h", c, odat, exp_d); end
        end
      end
      if (i_vld && i_rdy) q.push_back(idat);
      held_v = o_vld && !o_rdy;
      held_d = odat;
      step();
    end
    i_vld = 1'b0; o_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (o_vld && q.size() > 0) begin
        exp_d = q.pop_front();
        checks++; if (odat !== exp_d) begin errors++; $display("FAIL rnd_drain got %h exp %h", odat, exp_d); end
      end
      step();
    end
    checks++; if (q.size() != 0 || o_vld !== 1'b0) begin
      errors++; $display("FAIL rnd_loss got left=%0d o_vld=%b exp 0 0", q.size(), o_vld);
    end
  endtask

`ifdef A_SKID_BUF_STAT_EN
  task automatic test_stat();
    rst_n = 1'b0; i_vld = 1'b0; o_rdy = 1'b0;
    step();
    rst_n = 1'b1;
    i_vld = 1'b1; idat = 8'hC1;
    step();
    i_vld = 1'b0;
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stat_start got %0d exp 0", stall_cnt); end
    for (int c = 0; c < 10; c++) step();
    checks++; if (stall_cnt !== 16'd10) begin errors++; $display("FAIL stat_count got %0d exp 10", stall_cnt); end
    for (int c = 0; c < 70000; c++) step();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stat_sat got %h exp ffff", stall_cnt); end
    rst_n = 1'b0;
    #1;
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stat_reset got %h exp 0", stall_cnt); end
    step();
    rst_n = 1'b1;
    step();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_random();
`ifdef A_SKID_BUF_STAT_EN
    test_stat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
